// File: rtl/pipe_pkg.sv
// Shared front-end pipeline definitions: bubble-cause encoding and fetch constants.
package pipe_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_STALL = 2'd1,
    ST_WAIT  = 2'd2,
    ST_FLUSH = 2'd3
  } fetch_state_e;

  localparam logic [31:0] NOP_INST = 32'd0;
  localparam logic [31:0] PC_INC   = 32'd4;

endpackage

// File: rtl/fetch_stall_ctrl_if.sv
// Fetch-stage bundle: hazard/branch/imem inputs and PC, IF/ID and status outputs.
interface fetch_stall_ctrl_if;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic [31:0] imem_inst;
  logic        imem_ready;
  logic [31:0] pc;
  logic [31:0] if_id_inst;
  logic [31:0] if_id_pc4;
  logic [1:0]  state;
  logic [15:0] stall_cnt;
  logic        stall_err;
  logic        misalign;

  modport master (
    output stall, branch_taken, branch_target, imem_inst, imem_ready,
    input  pc, if_id_inst, if_id_pc4, state, stall_cnt, stall_err, misalign
  );

  modport slave (
    input  stall, branch_taken, branch_target, imem_inst, imem_ready,
    output pc, if_id_inst, if_id_pc4, state, stall_cnt, stall_err, misalign
  );
endinterface

// File: rtl/sat_counter.sv
// Up-counter with synchronous clear that sticks at MAX instead of wrapping.
module sat_counter #(
  parameter int               WIDTH = 16,
  parameter logic [WIDTH-1:0] MAX   = '1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] count
);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                        count <= '0;
    else if (clr)                   count <= '0;
    else if (inc && (count != MAX)) count <= count + WIDTH'(1);
  end

endmodule

// File: rtl/fetch_stall_ctrl.sv
// PC and IF/ID owner: applies redirect > stall > imem wait > run each cycle,
// and tracks stall statistics and a watchdog on consecutive bubbles.
module fetch_stall_ctrl
  import pipe_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          MAX_STALL = 8
) (
  input logic               clk,
  input logic               rst,
  fetch_stall_ctrl_if.slave bus
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  inst_q, inst_d;
  logic [31:0]  pc4_q, pc4_d;
  logic         misalign_q, misalign_d;
  logic         err_q;
  logic [15:0]  stall_cnt;
  logic [7:0]   run_len;
  logic         run_inc, wd_hit;

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_d    = ST_RUN;
    pc_d       = pc_q;
    inst_d     = NOP_INST;
    pc4_d      = 32'd0;
    misalign_d = misalign_q;
    if (bus.branch_taken) begin
      pc_d    = {bus.branch_target[31:2], 2'b00};
      state_d = ST_FLUSH;
      if (bus.branch_target[1:0] != 2'b00) misalign_d = 1'b1;
    end else if (bus.stall) begin
      state_d = ST_STALL;
    end else if (!bus.imem_ready) begin
      state_d = ST_WAIT;
    end else begin
      inst_d = bus.imem_inst;
      pc4_d  = pc_q + PC_INC;
      pc_d   = pc_q + PC_INC;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_RUN;
      pc_q       <= RESET_PC;
      inst_q     <= NOP_INST;
      pc4_q      <= 32'd0;
      misalign_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      inst_q     <= inst_d;
      pc4_q      <= pc4_d;
      misalign_q <= misalign_d;
      err_q      <= err_q | wd_hit;
    end
  end

  // Watchdog trips on the edge that takes the run length to MAX_STALL.
  assign run_inc = (state_d == ST_STALL) || (state_d == ST_WAIT);
  assign wd_hit  = run_inc && (run_len == 8'(MAX_STALL - 1));

  sat_counter #(.WIDTH(16), .MAX(16'hFFFF)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (state_d == ST_STALL),
    .clr   (1'b0),
    .count (stall_cnt)
  );

  sat_counter #(.WIDTH(8), .MAX(8'(MAX_STALL))) u_run_len (
    .clk   (clk),
    .rst   (rst),
    .inc   (run_inc),
    .clr   (!run_inc),
    .count (run_len)
  );

  assign bus.pc         = pc_q;
  assign bus.if_id_inst = inst_q;
  assign bus.if_id_pc4  = pc4_q;
  assign bus.state      = state_q;
  assign bus.stall_cnt  = stall_cnt;
  assign bus.stall_err  = err_q;
  assign bus.misalign   = misalign_q;

endmodule

// File: doc/fetch_stall_ctrl.md
# fetch_stall_ctrl

Front-end pipeline controller that acts on the load-use stall request produced by the hazard detector. It owns the PC register and the IF/ID pipeline register. On a stall it holds the PC, freezes the fetched instruction and injects a NOP bubble into IF/ID. It also handles taken-branch redirects, instruction-memory wait states and stall watchdog/statistics. It sits between instruction memory and the decode stage of the five-stage MIPS pipeline.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset
- MAX_STALL, 8, consecutive bubble cycles tolerated before `stall_err` sets (1..255)
- Ports:
  - clk  in  1  pipeline clock, all state updates on rising edge
  - rst  in  1  asynchronous, active-high reset
  - stall  in  1  load-use stall request from hazard detector (combinational, same cycle)
  - branch_taken  in  1  taken branch/jump resolved in ID this cycle
  - branch_target  in  32  redirect address
  - imem_inst  in  32  instruction at current `pc`
  - imem_ready  in  1  `imem_inst` valid this cycle
  - pc  out  32  current fetch address (registered)
  - if_id_inst  out  32  IF/ID instruction register; 32'd0 is the NOP bubble
  - if_id_pc4  out  32  IF/ID PC+4 register
  - state  out  2  bubble cause of current IF/ID content: 0 RUN, 1 STALL, 2 WAIT, 3 FLUSH
  - stall_cnt  out  16  saturating count of STALL bubbles since reset
  - stall_err  out  1  sticky watchdog flag
  - misalign  out  1  sticky, set when `branch_target[1:0]` != 0 on a taken redirect

## Operation
- Reset: pc=RESET_PC, if_id_inst=0, if_id_pc4=0, state=RUN, stall_cnt=0, stall_err=0, misalign=0, run-length counter=0.
- Each edge, the first matching case in this priority order applies:
  - **branch_taken**: pc <= {branch_target[31:2],2'b00}. IF/ID <= bubble (inst 0, pc4 0). state <= FLUSH. Sets misalign if target bits [1:0] are non-zero.
  - **stall**: pc holds. IF/ID <= bubble. state <= STALL. stall_cnt increments and saturates at 16'hFFFF.
  - **!imem_ready**: pc holds. IF/ID <= bubble. state <= WAIT.
  - **otherwise**: if_id_inst <= imem_inst. if_id_pc4 <= pc+4 (mod 2^32). pc <= pc+4. state <= RUN.
- Because the IF/ID register becomes a NOP, the hazard detector deasserts `stall` the next cycle. A single load-use stall therefore produces exactly one bubble.
- Watchdog:
  - The run-length counter increments on every STALL or WAIT bubble and clears on RUN or FLUSH.
  - When the counter reaches MAX_STALL, `stall_err` sets and stays set until reset.
  - The counter saturates at MAX_STALL.
- `stall_cnt`, `stall_err` and `misalign` are observation outputs only. They never alter flow.

## Timing
- All outputs are registered. There is no combinational path from input to output.
- Latency:
  - Input sampled at edge N takes effect in outputs after edge N.
  - Redirect: `pc` = target one cycle after `branch_taken`. The target instruction appears in `if_id_inst` one cycle later, provided `imem_ready` is high.
- Simultaneous events:
  - `branch_taken` with `stall`: branch wins. stall_cnt does not increment. The stalled instruction is discarded.
  - `stall` with `!imem_ready`: STALL is recorded.
- Wrap-around: pc = 32'hFFFF_FFFC advances to 0 with no flag.
- Reset mid-stall or mid-wait: all state returns to reset values immediately (asynchronous). First fetch is from RESET_PC.

## Structure
- Shared package `pipe_pkg`:
  - state encoding constants ST_RUN/ST_STALL/ST_WAIT/ST_FLUSH
  - NOP_INST = 32'd0
  - PC_INC = 32'd4
- One natural sub-module: `sat_counter` (parameterised width, increment, clear, saturate). Used twice: for `stall_cnt` and for the watchdog run-length counter.
- The PC/IF-ID next-state logic is a single priority mux in the top module.

## Test plan
- Reset with RESET_PC=32'h0040_0000, imem_ready=1, no events:
  - pc sequence 0x400000, 0x400004, 0x400008.
  - if_id_pc4 trails by one cycle.
  - state=RUN.
- Single-cycle stall at pc=0x10:
  - pc holds 0x10 for one extra cycle.
  - if_id_inst=0 and state=STALL for one cycle.
  - stall_cnt=1.
  - Instruction at 0x10 then enters IF/ID.
- branch_taken and stall together, target 0x0000_0103:
  - pc=0x100, state=FLUSH, stall_cnt unchanged, misalign=1.
- imem_ready low for MAX_STALL=8 cycles:
  - Eight WAIT bubbles, pc held.
  - stall_err=1 after the 8th edge and remains 1 after the stream resumes.
- pc=0xFFFF_FFFC, run: pc=0, if_id_pc4=0.
- Assert rst during a stall/wait sequence:
  - All outputs return to reset values before the next clock.
  - Fetch restarts at RESET_PC.
